// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Debug-side access state
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StRdata = 2'd2
    } dbg_state_e;

    // Full-word size/sign mask used by the debug loader by default
    localparam logic [3:0] DMEM_MASK_WORD = 4'b1111;

endpackage

// File: rtl/dmem_starve_counter.sv
// Counts consecutive cycles a granted-eligible debug request is blocked by the CPU.
module dmem_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wait_i,     // debug blocked this cycle; low clears the count
    output logic starved_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] Limit  = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             starved_q;

    // Saturating increment while blocked, clear otherwise
    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Flag follows the new count so it drops the cycle after a grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            starved_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            starved_q <= (cnt_d >= Limit);
        end
    end

    assign starved_o = starved_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (absolute priority) and a debug master.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        cpu_memwrite_i,
    input  logic        cpu_memread_i,
    input  logic [3:0]  cpu_sign_mask_i,
    output logic [31:0] cpu_rdata_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [3:0]  dbg_sign_mask_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_starved_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_memwrite_o,
    output logic        mem_memread_o,
    output logic [3:0]  mem_sign_mask_o,
    input  logic [31:0] mem_rdata_i
);

    dbg_state_e  state_q;
    logic        dbg_rvalid_q;
    logic [31:0] dbg_rdata_q;
    logic        cpu_busy;
    logic        dbg_issue;
    logic        wait_busy;

    assign cpu_busy  = cpu_memread_i | cpu_memwrite_i;
    assign dbg_issue = dbg_req_i & ~cpu_busy & ((state_q == StIdle) | (state_q == StWait));
    assign wait_busy = (state_q == StWait) & dbg_req_i & cpu_busy;

    assign dbg_gnt_o    = dbg_issue;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    // CPU samples this only in the cycle after its own load
    assign cpu_rdata_o  = mem_rdata_i;

    // Issue mux: CPU first, then an eligible debug access, else idle bus
    always_comb begin
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_memwrite_o  = 1'b0;
        mem_memread_o   = 1'b0;
        mem_sign_mask_o = '0;
        if (cpu_busy) begin
            mem_addr_o      = cpu_addr_i;
            mem_wdata_o     = cpu_wdata_i;
            mem_memwrite_o  = cpu_memwrite_i;
            mem_memread_o   = cpu_memread_i;
            mem_sign_mask_o = cpu_sign_mask_i;
        end else if (dbg_issue) begin
            mem_addr_o      = dbg_addr_i;
            mem_wdata_o     = dbg_wdata_i;
            mem_memwrite_o  = dbg_we_i;
            mem_memread_o   = ~dbg_we_i;
            mem_sign_mask_o = dbg_sign_mask_i;
        end
    end

    // Debug FSM with registered read-return outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            dbg_rvalid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (dbg_req_i) begin
                        if (cpu_busy) begin
                            state_q <= StWait;
                        end else if (!dbg_we_i) begin
                            state_q <= StRdata;
                        end
                    end
                end
                StWait: begin
                    if (!dbg_req_i) begin
                        state_q <= StIdle;
                    end else if (!cpu_busy) begin
                        state_q <= dbg_we_i ? StIdle : StRdata;
                    end
                end
                StRdata: begin
                    // Memory returns data the cycle after the read was issued
                    dbg_rdata_q  <= mem_rdata_i;
                    dbg_rvalid_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    dmem_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wait_i   (wait_busy),
        .starved_o(dbg_starved_o)
    );

endmodule
